// File: rtl/tank_bullet_ctrl_pkg.sv
// Shared types and screen constants for the tank projectile manager.
// BULLET_BOUNCE_EN adds a per-slot bounced bit to bullet_t.
package tank_pkg;

  typedef enum logic [2:0] {
    DIR_UP    = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_DOWN  = 3'd4
  } dir_t;

  localparam logic [9:0] X_MAX = 10'd639;
  localparam logic [9:0] Y_MAX = 10'd479;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    dir_t       dir;
`ifdef BULLET_BOUNCE_EN
    logic       bounced;
`endif
  } bullet_t;

  function automatic logic dir_valid(input logic [2:0] d);
    return (d >= 3'd1) && (d <= 3'd4);
  endfunction

endpackage

// File: rtl/tank_bullet_ctrl_if.sv
// Tank-stage / pixel-stage signal bundle for tank_bullet_ctrl.
interface tank_bullet_ctrl_if;
  logic       fire_req;
  logic [9:0] tank_X;
  logic [9:0] tank_Y;
  logic [2:0] tank_dir;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       is_bullet;
  logic       fire_ack;
  logic [3:0] bullet_count;

  modport master (
    output fire_req, tank_X, tank_Y, tank_dir, DrawX, DrawY,
    input  is_bullet, fire_ack, bullet_count
  );

  modport slave (
    input  fire_req, tank_X, tank_Y, tank_dir, DrawX, DrawY,
    output is_bullet, fire_ack, bullet_count
  );
endinterface

// File: rtl/tank_bullet_ctrl_bullet_slot.sv
// One bullet slot: spawn load, per-tick move/retire, pixel hit test.
// With BULLET_BOUNCE_EN the first edge violation reflects the bullet.
module bullet_slot
  import tank_pkg::*;
#(
  parameter logic [9:0] B_SIZE = 10'd4,
  parameter logic [9:0] SPEED  = 10'd4,
  parameter logic [9:0] XLIM   = 10'd636,
  parameter logic [9:0] YLIM   = 10'd476
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       tick,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  dir_t       spawn_dir,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output logic       active,
  output logic       active_nxt,
  output logic       hit
);

  localparam logic signed [10:0] SPD = signed'({1'b0, SPEED});
  localparam logic signed [10:0] XL  = signed'({1'b0, XLIM});
  localparam logic signed [10:0] YL  = signed'({1'b0, YLIM});

  bullet_t          b_q, b_d;
  logic signed [10:0] mx, my;
  logic             vx_lo, vx_hi, vy_lo, vy_hi, viol;

  // candidate position one step along the current direction
  always_comb begin
    mx = signed'({1'b0, b_q.x});
    my = signed'({1'b0, b_q.y});
    case (b_q.dir)
      DIR_UP:    my = my - SPD;
      DIR_DOWN:  my = my + SPD;
      DIR_LEFT:  mx = mx - SPD;
      DIR_RIGHT: mx = mx + SPD;
      default:   ;
    endcase
    vx_lo = mx < 11'sd0;
    vx_hi = mx > XL;
    vy_lo = my < 11'sd0;
    vy_hi = my > YL;
    viol  = vx_lo | vx_hi | vy_lo | vy_hi;
  end

  // next slot state: spawn load beats movement (a free slot never moves anyway)
  always_comb begin
    b_d = b_q;
    if (spawn) begin
      b_d.active = 1'b1;
      b_d.x      = spawn_x;
      b_d.y      = spawn_y;
      b_d.dir    = spawn_dir;
`ifdef BULLET_BOUNCE_EN
      b_d.bounced = 1'b0;
`endif
    end else if (tick && b_q.active) begin
      if (!viol) begin
        b_d.x = mx[9:0];
        b_d.y = my[9:0];
      end else begin
`ifdef BULLET_BOUNCE_EN
        if (b_q.bounced) begin
          b_d.active = 1'b0;
        end else begin
          // only the axis of travel can violate, so reversing dir reverses that axis
          b_d.bounced = 1'b1;
          b_d.x = vx_lo ? 10'd0 : (vx_hi ? XLIM : mx[9:0]);
          b_d.y = vy_lo ? 10'd0 : (vy_hi ? YLIM : my[9:0]);
          case (b_q.dir)
            DIR_UP:    b_d.dir = DIR_DOWN;
            DIR_DOWN:  b_d.dir = DIR_UP;
            DIR_LEFT:  b_d.dir = DIR_RIGHT;
            DIR_RIGHT: b_d.dir = DIR_LEFT;
            default:   ;
          endcase
        end
`else
        b_d.active = 1'b0;
`endif
      end
    end
  end

  // slot state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) b_q <= '0;
    else          b_q <= b_d;
  end

  assign active     = b_q.active;
  assign active_nxt = b_d.active;

  assign hit = b_q.active
            && ({1'b0, draw_x} >= {1'b0, b_q.x})
            && ({1'b0, draw_x} <= {1'b0, b_q.x} + {1'b0, B_SIZE} - 11'd1)
            && ({1'b0, draw_y} >= {1'b0, b_q.y})
            && ({1'b0, draw_y} <= {1'b0, b_q.y} + {1'b0, B_SIZE} - 11'd1);

endmodule

// File: rtl/tank_bullet_ctrl.sv
// Projectile manager: frame tick / fire edge detection, cooldown,
// lowest-free-slot allocation, pixel OR and active-slot count.
// Optional feature macro: BULLET_BOUNCE_EN (bullets reflect once at the edge).
module tank_bullet_ctrl
  import tank_pkg::*;
#(
  parameter int         NUM_BULLETS = 4,
  parameter logic [9:0] B_SIZE      = 10'd4,
  parameter logic [9:0] SPEED       = 10'd4,
  parameter logic [9:0] TANK_SIZE   = 10'd32,
  parameter logic [7:0] COOLDOWN    = 8'd15
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  tank_bullet_ctrl_if.slave  bus
);

  localparam logic [9:0] OFS  = (TANK_SIZE - B_SIZE) >> 1;
  localparam logic [9:0] XLIM = X_MAX - B_SIZE + 10'd1;
  localparam logic [9:0] YLIM = Y_MAX - B_SIZE + 10'd1;

  logic [2:0]             fc_sync;
  logic                   fire_q, fire_qq;
  logic [7:0]             cd_q;
  logic [3:0]             cnt_q, cnt_nxt;
  logic                   tick, fire_edge, accept, any_free;
  logic [NUM_BULLETS-1:0] act, act_nxt, hit, sel, spawn;

  // frame_clk: two sync flops plus one history flop for the rising edge
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) fc_sync <= '0;
    else          fc_sync <= {fc_sync[1:0], frame_clk};
  end
  assign tick = fc_sync[1] & ~fc_sync[2];

  // fire_req edge detector; resets to "already high" so a request held
  // through reset release must drop and rise again before it fires
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fire_q  <= 1'b1;
      fire_qq <= 1'b1;
    end else begin
      fire_q  <= bus.fire_req;
      fire_qq <= fire_q;
    end
  end
  assign fire_edge = fire_q & ~fire_qq;

  // lowest-index free slot (uses registered state: a slot retiring this
  // cycle is not offered until the next one)
  always_comb begin
    sel      = '0;
    any_free = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!act[i] && !any_free) begin
        sel[i]   = 1'b1;
        any_free = 1'b1;
      end
    end
  end

  assign accept = fire_edge && (cd_q == 8'd0) && any_free && dir_valid(bus.tank_dir);
  assign spawn  = accept ? sel : '0;

  // cooldown: load on accept wins over the tick decrement
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                  cd_q <= 8'd0;
    else if (accept)               cd_q <= COOLDOWN;
    else if (tick && cd_q != 8'd0) cd_q <= cd_q - 8'd1;
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    bullet_slot #(
      .B_SIZE (B_SIZE),
      .SPEED  (SPEED),
      .XLIM   (XLIM),
      .YLIM   (YLIM)
    ) u_slot (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .tick       (tick),
      .spawn      (spawn[g]),
      .spawn_x    (bus.tank_X + OFS),
      .spawn_y    (bus.tank_Y + OFS),
      .spawn_dir  (dir_t'(bus.tank_dir)),
      .draw_x     (bus.DrawX),
      .draw_y     (bus.DrawY),
      .active     (act[g]),
      .active_nxt (act_nxt[g]),
      .hit        (hit[g])
    );
  end

  // popcount of next slot state so the registered count matches slots after the edge
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_BULLETS; i++) cnt_nxt = cnt_nxt + {3'b0, act_nxt[i]};
  end

  // registered active-slot count
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_nxt;
  end

  assign bus.fire_ack     = accept;
  assign bus.is_bullet    = |hit;
  assign bus.bullet_count = cnt_q;

endmodule

// File: tb/tb_tank_bullet_ctrl.sv
// Self-checking bench for tank_bullet_ctrl; expected ack counts go through a
// scoreboard queue, positions come from hand-derived constants.
module tb_tank_bullet_ctrl;
  import tank_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n;
  logic frame_clk;
  tank_bullet_ctrl_if bus();

  tank_bullet_ctrl dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  always #10 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic e);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    #1;
    chk(tag, {31'b0, bus.is_bullet}, {31'b0, e});
  endtask

  // one frame_clk period; the synchronised tick lands inside it
  task automatic ftick();
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic nticks(input int n);
    repeat (n) ftick();
  endtask

  // raise and hold fire_req, count ack pulses while held
  task automatic fire(input string tag, input int exp_acks);
    int acks = 0;
    exp_q.push_back(exp_acks);
    @(negedge Clk);
    bus.fire_req = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      if (bus.fire_ack) acks++;
    end
    bus.fire_req = 1'b0;
    repeat (2) @(negedge Clk);
    chk(tag, acks, exp_q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    Reset_n      = 1'b0;
    frame_clk    = 1'b0;
    bus.fire_req = 1'b0;
    bus.tank_X   = '0;
    bus.tank_Y   = '0;
    bus.tank_dir = 3'd1;
    bus.DrawX    = '0;
    bus.DrawY    = '0;
    repeat (3) @(negedge Clk);
    chk("rst_is_bullet", {31'b0, bus.is_bullet}, 0);
    chk("rst_fire_ack", {31'b0, bus.fire_ack}, 0);
    chk("rst_count", {28'b0, bus.bullet_count}, 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // invalid direction is dropped
    bus.tank_X = 10'd100; bus.tank_Y = 10'd380; bus.tank_dir = 3'd0;
    fire("bad_dir_ack", 0);
    chk("bad_dir_cnt", {28'b0, bus.bullet_count}, 0);

    // single shot upward
    bus.tank_dir = 3'd1;
    fire("shot1_ack", 1);
    chk("shot1_cnt", {28'b0, bus.bullet_count}, 1);
    pix("shot1_spawn", 114, 394, 1'b1);
    nticks(3);
    pix("up3_hit", 114, 382, 1'b1);
    pix("up3_miss_x", 118, 382, 1'b0);
    pix("up3_corner", 117, 385, 1'b1);
    pix("up3_miss_y", 114, 386, 1'b0);

    // cooldown: 5 ticks after the shot is too early, 15 is enough
    nticks(2);
    fire("cd_drop_ack", 0);
    chk("cd_drop_cnt", {28'b0, bus.bullet_count}, 1);
    nticks(10);
    fire("cd_ok_ack", 1);
    chk("cd_ok_cnt", {28'b0, bus.bullet_count}, 2);
    pix("slot0_y334", 114, 334, 1'b1);

    // reset mid-flight with fire_req held across release
    @(negedge Clk);
    bus.fire_req = 1'b1;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("midrst_is_bullet", {31'b0, bus.is_bullet}, 0);
    chk("midrst_count", {28'b0, bus.bullet_count}, 0);
    chk("midrst_ack", {31'b0, bus.fire_ack}, 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    exp_q.push_back(0);
    acks = 0;
    repeat (6) begin
      @(negedge Clk);
      if (bus.fire_ack) acks++;
    end
    bus.fire_req = 1'b0;
    repeat (2) @(negedge Clk);
    chk("held_rst_ack", acks, exp_q.pop_front());
    chk("post_rst_cnt", {28'b0, bus.bullet_count}, 0);

    // exit at the left edge
    bus.tank_X = 10'd0; bus.tank_Y = 10'd200; bus.tank_dir = 3'd3;
    fire("exit_ack", 1);
    pix("exit_spawn", 14, 214, 1'b1);
    ftick(); pix("exit_x10", 10, 214, 1'b1);
    ftick(); pix("exit_x6", 6, 214, 1'b1);
    ftick(); pix("exit_x2", 2, 214, 1'b1);
    chk("exit_cnt_before", {28'b0, bus.bullet_count}, 1);
    ftick();
`ifdef BULLET_BOUNCE_EN
    chk("bounce_cnt", {28'b0, bus.bullet_count}, 1);
    pix("bounce_x0", 0, 214, 1'b1);
    ftick();
    pix("bounce_right_x4", 4, 214, 1'b1);
    pix("bounce_right_x0", 0, 214, 1'b0);
`else
    chk("exit_cnt_after", {28'b0, bus.bullet_count}, 0);
    pix("exit_gone_x0", 0, 214, 1'b0);
    pix("exit_gone_x2", 2, 214, 1'b0);
`endif

    // full: four shots then a fifth is refused
    do_reset();
    bus.tank_X = 10'd300; bus.tank_Y = 10'd0; bus.tank_dir = 3'd4;
    for (int i = 1; i <= 4; i++) begin
      fire($sformatf("full_ack%0d", i), 1);
      chk($sformatf("full_cnt%0d", i), {28'b0, bus.bullet_count}, 32'(i));
      nticks(15);
    end
    fire("full_5th_ack", 0);
    chk("full_5th_cnt", {28'b0, bus.bullet_count}, 4);

    // simultaneous fire edge and tick
    do_reset();
    bus.tank_X = 10'd300; bus.tank_Y = 10'd0; bus.tank_dir = 3'd4;
    fire("sim_a_ack", 1);
    nticks(15);
    pix("sim_a_y74", 314, 74, 1'b1);
    bus.tank_X = 10'd100;
    frame_clk = 1'b1;
    @(negedge Clk);
    bus.fire_req = 1'b1;
    exp_q.push_back(1);
    @(negedge Clk);
    chk("sim_ack", {31'b0, bus.fire_ack}, 32'(exp_q.pop_front()));
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    bus.fire_req = 1'b0;
    repeat (4) @(negedge Clk);
    pix("sim_a_moved", 314, 78, 1'b1);
    pix("sim_a_left", 314, 77, 1'b0);
    pix("sim_new_spawn", 114, 14, 1'b1);
    pix("sim_new_unmoved", 114, 18, 1'b0);
    chk("sim_cnt", {28'b0, bus.bullet_count}, 2);
    nticks(14);
    fire("sim_cd14_ack", 0);
    ftick();
    fire("sim_cd15_ack", 1);
    chk("sim_final_cnt", {28'b0, bus.bullet_count}, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
